mc_ctrl: RTL

Multi-cycle control unit for the MIPS core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the 4-bit ALU opcode, the ALU operand selects, the PC/IR/register-file/memory write enables and the writeback muxes. It latches the ALU overflow flag so that signed add/sub results are suppressed on overflow. It also keeps a count of retired instructions.

---
 rtl/mc_pkg.sv | 68 ++++++
 rtl/mc_decode.sv | 79 +++++++
 rtl/mc_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// opcode/funct fields, ALU opcodes, mux selects and instruction classes.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CLS_RTYPE = 3'd0,
    CLS_ORI   = 3'd1,
    CLS_LUI   = 3'd2,
    CLS_LW    = 3'd3,
    CLS_SW    = 3'd4,
    CLS_BEQ   = 3'd5,
    CLS_J     = 3'd6,
    CLS_NOP   = 3'd7
  } instr_class_e;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  localparam logic [3:0] ALU_ADDU = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b1001;
  localparam logic [3:0] ALU_SUBU = 4'b1000;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b1110;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1111;
  localparam logic [3:0] ALU_LUI  = 4'b0110;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] SRC_B_RT   = 2'd0;
  localparam logic [1:0] SRC_B_SIMM = 2'd1;
  localparam logic [1:0] SRC_B_ZIMM = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: classifies the IR and produces the
// EXEC-stage ALU controls plus the writeback destination select.
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  instr_class,
  output logic [3:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        reg_dst,
  output logic        is_ovf_op
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_fields;

  assign op            = instr[31:26];
  assign funct         = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    instr_class = CLS_NOP;
    alu_op      = ALU_ADDU;
    alu_src_a   = 1'b0;
    alu_src_b   = SRC_B_RT;
    reg_dst     = 1'b0;
    is_ovf_op   = 1'b0;
    case (op)
      OP_SPECIAL: begin
        instr_class = CLS_RTYPE;
        reg_dst     = 1'b1;
        case (funct)
          FN_ADDU: alu_op = ALU_ADDU;
          FN_ADD:  begin alu_op = ALU_ADD; is_ovf_op = 1'b1; end
          FN_SUBU: alu_op = ALU_SUBU;
          FN_SUB:  begin alu_op = ALU_SUB; is_ovf_op = 1'b1; end
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLL:  begin alu_op = ALU_SLL; alu_src_a = 1'b1; end
          FN_SRL:  begin alu_op = ALU_SRL; alu_src_a = 1'b1; end
          FN_SRA:  begin alu_op = ALU_SRA; alu_src_a = 1'b1; end
          FN_SLLV: alu_op = ALU_SLL;
          FN_SRLV: alu_op = ALU_SRL;
          FN_SRAV: alu_op = ALU_SRA;
          default: begin instr_class = CLS_NOP; reg_dst = 1'b0; end
        endcase
      end
      OP_ORI: begin
        instr_class = CLS_ORI;
        alu_op      = ALU_OR;
        alu_src_b   = SRC_B_ZIMM;
      end
      OP_LUI: begin
        instr_class = CLS_LUI;
        alu_op      = ALU_LUI;
        alu_src_b   = SRC_B_SIMM;
      end
      OP_LW: begin
        instr_class = CLS_LW;
        alu_src_b   = SRC_B_SIMM;
      end
      OP_SW: begin
        instr_class = CLS_SW;
        alu_src_b   = SRC_B_SIMM;
      end
      OP_BEQ: begin
        instr_class = CLS_BEQ;
        alu_op      = ALU_SUBU;
      end
      OP_J:    instr_class = CLS_J;
      default: instr_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, suppresses
// overflowing signed results at writeback and counts retired instructions.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             overflow,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             ir_we,
  output logic [3:0]       alu_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             mem_we,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             wd_src,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_e            state_q, state_d;
  logic              ov_q, ov_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic [2:0]        dec_class_raw;
  instr_class_e      dec_class;
  logic [3:0]        dec_alu_op;
  logic              dec_src_a;
  logic [1:0]        dec_src_b;
  logic              dec_reg_dst;
  logic              dec_ovf_op;

  mc_decode u_decode (
    .instr       (instr),
    .instr_class (dec_class_raw),
    .alu_op      (dec_alu_op),
    .alu_src_a   (dec_src_a),
    .alu_src_b   (dec_src_b),
    .reg_dst     (dec_reg_dst),
    .is_ovf_op   (dec_ovf_op)
  );

  assign dec_class = instr_class_e'(dec_class_raw);
  assign state     = state_q;
  assign retired   = retired_q;

  always_comb begin
    state_d   = state_q;
    ov_d      = ov_q;
    retired_d = retired_q;
    pc_we     = 1'b0;
    pc_src    = PC_SRC_SEQ;
    ir_we     = 1'b0;
    alu_op    = ALU_ADDU;
    alu_src_a = 1'b0;
    alu_src_b = SRC_B_RT;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    reg_dst   = 1'b0;
    wd_src    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (dec_class == CLS_J) begin
          pc_we   = 1'b1;
          pc_src  = PC_SRC_JUMP;
          state_d = ST_FETCH;
        end else if (dec_class == CLS_NOP) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_op    = dec_alu_op;
        alu_src_a = dec_src_a;
        alu_src_b = dec_src_b;
        ov_d      = dec_ovf_op & overflow;
        if (dec_class == CLS_BEQ) begin
          if (zero) begin
            pc_we  = 1'b1;
            pc_src = PC_SRC_BRANCH;
          end
          state_d = ST_FETCH;
        end else if (dec_class == CLS_LW || dec_class == CLS_SW) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (dec_class == CLS_LW) begin
          state_d = ST_WB;
        end else begin
          mem_we  = (dec_class == CLS_SW);
          state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        reg_we  = ~ov_q;
        reg_dst = dec_reg_dst;
        wd_src  = (dec_class == CLS_LW);
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    // Only a completed instruction counts, not recovery from an illegal code.
    if (state_d == ST_FETCH && state_q != ST_FETCH &&
        (state_q == ST_DECODE || state_q == ST_EXEC ||
         state_q == ST_MEM || state_q == ST_WB)) begin
      retired_d = retired_q + CNT_W'(1);
    end

    if (reset) begin
      pc_we  = 1'b0;
      ir_we  = 1'b0;
      mem_we = 1'b0;
      reg_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      ov_q      <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ov_q      <= ov_d;
      retired_q <= retired_d;
    end
  end

endmodule
